// File: rtl/avmm_ocram.sv
// avmm_ocram: on-chip RAM behind an Avalon-MM pipelined slave port.
// The port has in-lane byte enables and WAIT_STATES stall cycles before each
// transfer is accepted. Reads complete after READ_LATENCY cycles with an
// OKAY/SLVERR response.
// Optional build macro OCRAM_CLEAR_EN: after reset the array is swept to zero
// one word per cycle while waitrequest is held high.
module avmm_ocram #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 65536,
  parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH),
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic [1:0]              response
);

  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned WCNT_WIDTH = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [WCNT_WIDTH-1:0]   wait_cnt;
  logic                    req;
  logic                    busy;
  logic                    wait_hold;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
  logic [1:0]              pipe_resp [READ_LATENCY];

  // Request decode. A write wins over a simultaneous read; that read is dropped.
  assign req         = read | write;
  assign busy        = reset | (state != ST_IDLE);
  assign wait_hold   = req && (wait_cnt != WCNT_WIDTH'(WAIT_STATES));
  assign waitrequest = busy | wait_hold;
  assign accept      = req & ~waitrequest;
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;
  assign in_range    = (32'(address) < DEPTH);
  assign rd_word     = in_range ? mem[address] : '0;

`ifdef OCRAM_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] clr_addr;

  // Sweep state: CLEAR walks every word once after reset, then IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + ADDR_WIDTH'(1);
      if (clr_addr == LAST_ADDR) begin
        state <= ST_IDLE;
      end
    end
  end

  // Storage: the sweep writes zeros, otherwise accepted writes update enabled lanes.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc && in_range) begin
      for (int unsigned k = 0; k < BE_WIDTH; k++) begin
        if (byteenable[k]) begin
          mem[address][8*k +: 8] <= writedata[8*k +: 8];
        end
      end
    end
  end
`else
  // Without the sweep the slave is ready as soon as reset deasserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= ST_IDLE;
    end
  end

  // Storage: accepted in-range writes update only the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int unsigned k = 0; k < BE_WIDTH; k++) begin
        if (byteenable[k]) begin
          mem[address][8*k +: 8] <= writedata[8*k +: 8];
        end
      end
    end
  end
`endif

  // Wait-state counter: counts stalled edges and restarts on accept or a dropped request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!req || accept || busy) begin
      wait_cnt <= '0;
    end else if (wait_hold) begin
      wait_cnt <= wait_cnt + WCNT_WIDTH'(1);
    end
  end

  // Read return pipeline. Data only moves with a valid, so the last stage holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
        pipe_resp[i] <= RESP_OKAY;
      end
    end else begin
      pipe_valid[0] <= rd_acc;
      if (rd_acc) begin
        pipe_data[0] <= rd_word;
        pipe_resp[0] <= in_range ? RESP_OKAY : RESP_SLVERR;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_resp[i] <= pipe_resp[i-1];
        end
      end
    end
  end

  assign readdatavalid = pipe_valid[READ_LATENCY-1];
  assign readdata      = pipe_data[READ_LATENCY-1];
  assign response      = pipe_resp[READ_LATENCY-1];

endmodule

// File: tb/tb_avmm_ocram.sv
// tb_avmm_ocram: directed bench for avmm_ocram.
// Instance A: DEPTH=1000, READ_LATENCY=2, WAIT_STATES=0.
// Instance B: DEPTH=16, READ_LATENCY=3, WAIT_STATES=3.
// The clear-sweep checks are built only when OCRAM_CLEAR_EN is defined.
module tb_avmm_ocram;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;
  localparam int WS_B  = 3;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [9:0]  address = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic        wait_a, rvalid_a, wait_b, rvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  resp_a, resp_b;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  rsp_t qa[$];
  rsp_t qb[$];

  always #5 clk = ~clk;

  avmm_ocram #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(10),
               .READ_LATENCY(LAT_A), .WAIT_STATES(0)) u_a (
    .clk(clk), .reset(rst_a), .address(address), .read(rd_a), .write(wr_a),
    .byteenable(be), .writedata(wdata), .waitrequest(wait_a),
    .readdata(rdata_a), .readdatavalid(rvalid_a), .response(resp_a));

  avmm_ocram #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4),
               .READ_LATENCY(LAT_B), .WAIT_STATES(WS_B)) u_b (
    .clk(clk), .reset(rst_b), .address(address[3:0]), .read(rd_b), .write(wr_b),
    .byteenable(be), .writedata(wdata), .waitrequest(wait_b),
    .readdata(rdata_b), .readdatavalid(rvalid_b), .response(resp_b));

  // Response monitor: log every readdatavalid with the index of the edge that sampled it.
  always @(posedge clk) begin
    if (rvalid_a) qa.push_back('{data: rdata_a, resp: resp_a, cyc: cyc});
    if (rvalid_b) qb.push_back('{data: rdata_b, resp: resp_b, cyc: cyc});
    cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One transfer on instance sel (0=A, 1=B); returns stalled edges and the acceptance edge index.
  task automatic xfer(input bit sel, input bit r, input bit w, input logic [9:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      output int waits, output int acc);
    address = a;
    be      = b;
    wdata   = d;
    if (sel) begin rd_b = r; wr_b = w; end
    else     begin rd_a = r; wr_a = w; end
    waits = 0;
    #1;
    while ((sel ? wait_b : wait_a) !== 1'b0 && waits < 50) begin
      tick(1);
      waits++;
    end
    if (waits >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL xfer_timeout: waitrequest=%b after %0d cycles, required 0", sel ? wait_b : wait_a, waits);
    end else begin
      @(posedge clk);
      #1;
    end
    acc  = cyc - 1;
    rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
  endtask

  task automatic wr(input bit sel, input logic [9:0] a, input logic [31:0] d,
                    input logic [3:0] b, input string tag);
    int w, acc;
    xfer(sel, 1'b0, 1'b1, a, b, d, w, acc);
    check({tag, "_waits"}, 64'(w), sel ? 64'(WS_B) : 64'd0);
  endtask

  // Single read with full response check: count, data, response code and latency.
  task automatic rd_chk(input bit sel, input logic [9:0] a, input logic [31:0] ed,
                        input logic [1:0] er, input string tag);
    int   w, acc, lat, n;
    rsp_t r;
    r   = '{data: 'x, resp: 'x, cyc: -1};
    lat = sel ? LAT_B : LAT_A;
    if (sel) qb.delete(); else qa.delete();
    xfer(sel, 1'b1, 1'b0, a, 4'b0001, 32'h0, w, acc);
    check({tag, "_waits"}, 64'(w), sel ? 64'(WS_B) : 64'd0);
    tick(lat + 1);
    n = sel ? qb.size() : qa.size();
    check({tag, "_count"}, 64'(n), 64'd1);
    if (n > 0) r = sel ? qb[0] : qa[0];
    check({tag, "_data"}, 64'(r.data), 64'(ed));
    check({tag, "_resp"}, 64'(r.resp), 64'(er));
    check({tag, "_latency"}, 64'(r.cyc - acc), 64'(lat));
  endtask

  initial begin
    int w, n;
    int accs[4];
    int acc;

    // Reset values while reset is held.
    #2;
    check("rst_a_wait",  64'(wait_a),   64'd1);
    check("rst_a_valid", 64'(rvalid_a), 64'd0);
    check("rst_a_data",  64'(rdata_a),  64'd0);
    check("rst_a_resp",  64'(resp_a),   64'd0);
    check("rst_b_wait",  64'(wait_b),   64'd1);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    n = 0;
    while ((wait_a !== 1'b0 || wait_b !== 1'b0) && n < 3000) begin
      tick(1);
      n++;
    end
    check("init_ready_a", 64'(wait_a), 64'd0);
    check("init_ready_b", 64'(wait_b), 64'd0);

    // Full write, low-lane write, then read: lanes merge and latency is 2.
    wr(0, 10'd5, 32'hDEADBEEF, 4'b1111, "wr5_full");
    wr(0, 10'd5, 32'h000000AA, 4'b0001, "wr5_lane0");
    rd_chk(0, 10'd5, 32'hDEADBEAA, 2'b00, "rd5");

    // byteenable=0 leaves the word unchanged.
    wr(0, 10'd5, 32'hFFFFFFFF, 4'b0000, "wr5_nobe");
    rd_chk(0, 10'd5, 32'hDEADBEAA, 2'b00, "rd5_nobe");

    // Back-to-back pipelined reads of words 0..3.
    for (int i = 0; i < 4; i++) wr(0, 10'(i), 32'h10 + 32'(i), 4'hF, "pre");
    qa.delete();
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, 1'b0, 10'(i), 4'hF, 32'h0, w, accs[i]);
      check("pipe_waits", 64'(w), 64'd0);
    end
    check("pipe_b2b_accept", 64'(accs[3] - accs[0]), 64'd3);
    tick(4);
    check("pipe_count", 64'(qa.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < qa.size()) begin
        check("pipe_data", 64'(qa[i].data), 64'h10 + 64'(i));
        check("pipe_cyc",  64'(qa[i].cyc),  64'(accs[0] + LAT_A + i));
      end
    end

    // Read and write together: the write lands, the read gives no response.
    qa.delete();
    xfer(0, 1'b1, 1'b1, 10'd7, 4'hF, 32'h77777777, w, acc);
    tick(4);
    check("rw_no_valid", 64'(qa.size()), 64'd0);
    rd_chk(0, 10'd7, 32'h77777777, 2'b00, "rw_prio");

    // Out of range: write dropped, read errors; last in-range word intact.
    wr(0, 10'd999,  32'h12345678, 4'hF, "wr999");
    wr(0, 10'd1000, 32'h00000055, 4'hF, "wr1000");
    rd_chk(0, 10'd1000, 32'h0, 2'b10, "rd1000");
    rd_chk(0, 10'd999,  32'h12345678, 2'b00, "rd999");
    tick(3);
    check("hold_data",  64'(rdata_a),  64'h12345678);
    check("hold_valid", 64'(rvalid_a), 64'd0);

    // Three wait states on a write and on the following read.
    wr(1, 10'd2, 32'hCAFEF00D, 4'hF, "ws_wr");
    rd_chk(1, 10'd2, 32'hCAFEF00D, 2'b00, "ws_rd");

    // A request dropped mid-stall restarts the wait count from zero.
    address = 10'd2;
    rd_b    = 1'b1;
    tick(2);
    check("abort_stalled", 64'(wait_b), 64'd1);
    rd_b = 1'b0;
    tick(1);
    rd_chk(1, 10'd2, 32'hCAFEF00D, 2'b00, "ws_restart");

`ifdef OCRAM_CLEAR_EN
    for (int i = 0; i < 16; i++) wr(1, 10'(i), 32'hA0 + 32'(i), 4'hF, "preload");
    rd_chk(1, 10'd9, 32'hA9, 2'b00, "preload_rd");
`endif

    // Reset one cycle after a read is accepted: no late response, outputs at reset values.
    qb.delete();
    xfer(1, 1'b1, 1'b0, 10'd2, 4'hF, 32'h0, w, acc);
    tick(1);
    rst_b = 1'b1;
    #1;
    check("midrst_wait",  64'(wait_b),   64'd1);
    check("midrst_valid", 64'(rvalid_b), 64'd0);
    check("midrst_data",  64'(rdata_b),  64'd0);
    check("midrst_resp",  64'(resp_b),   64'd0);
    tick(2);
    rst_b = 1'b0;

`ifdef OCRAM_CLEAR_EN
    n = 0;
    while (wait_b === 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check("clear_cycles", 64'(n), 64'd16);
    check("midrst_no_late_valid", 64'(qb.size()), 64'd0);
    for (int i = 0; i < 16; i++) rd_chk(1, 10'(i), 32'h0, 2'b00, "clear_rd");
`else
    tick(6);
    check("midrst_no_late_valid", 64'(qb.size()), 64'd0);
    rd_chk(1, 10'd2, 32'hCAFEF00D, 2'b00, "retain_rd");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
